instr_fetch: RTL and testbench

- Instruction-fetch front end: the supplier side of the core's PC/Instr inputs.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request channel, with one outstanding request at a time.
- Presents each fetched {PC, Instr} pair to the core with a valid/ready handshake.
- Accepts redirects (branch/jump target) from the core and discards any stale in-flight response.

---
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner issuing one-outstanding imem reads and presenting {PC, Instr} pairs with redirect/kill handling
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d, instr_q, instr_d, redir;
    logic            kill_q, kill_d, valid_q, valid_d, req_q, req_d, hs;
    assign redir          = redirect_pc & ~XLEN'(3);
    assign hs             = req_q && imem_req_ready;
    assign imem_req_valid = req_q;
    assign imem_addr      = fetch_pc_q;
    assign PC             = pc_q;
    assign Instr          = instr_q;
    assign instr_valid    = valid_q;
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        case (state_q)
            S_REQ: begin
                fetch_pc_d = redirect_valid ? redir : fetch_pc_q;
                state_d    = hs ? S_WAIT : S_REQ;
                kill_d     = hs && redirect_valid;
            end
            S_WAIT: begin
                fetch_pc_d = redirect_valid ? redir : fetch_pc_q;
                if (imem_rsp_valid) begin
                    kill_d  = 1'b0;
                    state_d = (kill_q || redirect_valid) ? S_REQ : S_HOLD;
                    valid_d = !(kill_q || redirect_valid);
                    pc_d    = valid_d ? fetch_pc_q : pc_q;
                    instr_d = valid_d ? imem_rdata : instr_q;
                end else begin
                    kill_d = kill_q || redirect_valid;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                    fetch_pc_d = redirect_valid ? redir : fetch_pc_q + XLEN'(4);
                end
            end
            default: state_d = S_REQ;
        endcase
        // request flop tracks the next state so imem_req_valid is a pure register output
        req_d = (state_d == S_REQ);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            pc_q       <= RESET_PC;
            instr_q    <= XLEN'(32'h0000_0013);
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a 1/2-cycle memory model and a second instance for PC wrap
module tb_instr_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset = 1'b1, req_valid, req_ready = 1'b1, rsp_valid;
    logic [31:0] addr, rdata, pc, instr, redirect_pc = '0;
    logic        ivalid, instr_ready = 1'b0, redirect_valid = 1'b0;
    logic        mem_en = 1'b0, lat2 = 1'b0, man_rsp = 1'b0, stray_ok = 1'b0, outst = 1'b0;
    logic [31:0] man_rdata = '0, d1 = '0, d2 = '0;
    logic        r1 = 1'b0, r2 = 1'b0;
    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] acc_a[$], pres_pc[$], pres_in[$];
    int          acc_t[$];
    logic        w_reset = 1'b1, w_req_valid, w_rsp = 1'b0, w_ivalid, zero1 = 1'b0, one1 = 1'b1;
    logic [31:0] w_addr, w_rdata = '0, w_pc, w_instr, zero32 = '0;
    logic [31:0] w_acc[$], w_pres_pc[$], w_pres_in[$];
    instr_fetch dut (
        .clk(clk), .reset(reset), .imem_req_valid(req_valid), .imem_req_ready(req_ready),
        .imem_addr(addr), .imem_rsp_valid(rsp_valid), .imem_rdata(rdata), .PC(pc), .Instr(instr),
        .instr_valid(ivalid), .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );
    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(w_reset), .imem_req_valid(w_req_valid), .imem_req_ready(one1),
        .imem_addr(w_addr), .imem_rsp_valid(w_rsp), .imem_rdata(w_rdata), .PC(w_pc), .Instr(w_instr),
        .instr_valid(w_ivalid), .instr_ready(one1), .redirect_valid(zero1), .redirect_pc(zero32)
    );
    assign rsp_valid = man_rsp | (lat2 ? r2 : r1);
    assign rdata     = man_rsp ? man_rdata : (lat2 ? d2 : d1);
    always @(posedge clk) begin
        r1  <= mem_en && req_valid && req_ready;
        d1  <= addr ^ 32'hA5A5_0000;
        r2  <= r1;
        d2  <= d1;
        cyc <= cyc + 1;
        if (req_valid && req_ready) begin
            acc_a.push_back(addr);
            acc_t.push_back(cyc);
        end
        if (ivalid && instr_ready) begin
            pres_pc.push_back(pc);
            pres_in.push_back(instr);
        end
        w_rsp   <= w_req_valid;
        w_rdata <= w_addr ^ 32'hA5A5_0000;
        if (w_req_valid) w_acc.push_back(w_addr);
        if (w_ivalid) begin
            w_pres_pc.push_back(w_pc);
            w_pres_in.push_back(w_instr);
        end
        if (reset) outst <= 1'b0;
        else if (req_valid && req_ready) outst <= 1'b1;
        else if (rsp_valid) outst <= 1'b0;
        assert (!(rsp_valid && !outst && !stray_ok && !reset))
            else $error("protocol: imem response with no outstanding request");
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_q();
        acc_a.delete();
        acc_t.delete();
        pres_pc.delete();
        pres_in.delete();
    endtask
    task automatic do_reset();
        mem_en = 1'b0;
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        man_rsp = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        mem_en = 1'b1;
        clear_q();
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ivalid); end
        if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
        if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
        if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req_valid); end
        reset = 1'b0;
        mem_en = 1'b1;
        clear_q();
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL release_req got=%b exp=0", req_valid); end
        tick();
        checks += 2;
        if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", req_valid); end
        if (addr !== 32'h0) begin errors++; $display("FAIL first_addr got=%h exp=00000000", addr); end
    endtask
    task automatic test_stream();
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && pres_pc.size() < 3; i++) tick();
        checks++;
        if (pres_pc.size() < 3 || acc_t.size() < 3) begin
            errors++;
            $display("FAIL stream_count got=%0d exp=3", pres_pc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks += 2;
                if (pres_pc[k] !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got=%h exp=%h", k, pres_pc[k], 32'(4 * k)); end
                if (pres_in[k] !== (32'(4 * k) ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_instr%0d got=%h exp=%h", k, pres_in[k], 32'(4 * k) ^ 32'hA5A5_0000); end
            end
            checks += 2;
            if (acc_t[1] - acc_t[0] != 3) begin errors++; $display("FAIL stream_period0 got=%0d exp=3", acc_t[1] - acc_t[0]); end
            if (acc_t[2] - acc_t[1] != 3) begin errors++; $display("FAIL stream_period1 got=%0d exp=3", acc_t[2] - acc_t[1]); end
        end
    endtask
    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 40 && !ivalid; i++) tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 40 && !(ivalid && pc == 32'h4); i++) tick();
        checks++;
        if (!(ivalid === 1'b1 && pc === 32'h4)) begin errors++; $display("FAIL bp_present got=%b/%h exp=1/00000004", ivalid, pc); end
        acc_a.delete();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks += 4;
            if (ivalid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%b exp=1", k, ivalid); end
            if (pc !== 32'h4) begin errors++; $display("FAIL bp_pc%0d got=%h exp=00000004", k, pc); end
            if (instr !== 32'hA5A5_0004) begin errors++; $display("FAIL bp_instr%0d got=%h exp=a5a50004", k, instr); end
            if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req%0d got=%b exp=0", k, req_valid); end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 40 && acc_a.size() < 1; i++) tick();
        checks++;
        if (acc_a.size() < 1) begin errors++; $display("FAIL bp_next_req got=none exp=00000008"); end
        else if (acc_a[0] !== 32'h8) begin errors++; $display("FAIL bp_next_req got=%h exp=00000008", acc_a[0]); end
    endtask
    task automatic test_redirect_wait();
        do_reset();
        lat2 = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && !(req_valid && addr == 32'h8); i++) tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        clear_q();
        for (int i = 0; i < 60 && pres_pc.size() < 1; i++) tick();
        checks += 3;
        if (acc_a.size() < 1 || acc_a[0] !== 32'h100) begin errors++; $display("FAIL rw_req got=%h exp=00000100", acc_a.size() ? acc_a[0] : 32'hx); end
        if (pres_pc.size() < 1 || pres_pc[0] !== 32'h100) begin errors++; $display("FAIL rw_pc got=%h exp=00000100", pres_pc.size() ? pres_pc[0] : 32'hx); end
        if (pres_in.size() < 1 || pres_in[0] !== 32'hA5A5_0100) begin errors++; $display("FAIL rw_instr got=%h exp=a5a50100", pres_in.size() ? pres_in[0] : 32'hx); end
        lat2 = 1'b0;
    endtask
    task automatic test_redirect_rsp_same();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && !(req_valid && addr == 32'h4); i++) tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0301;
        tick();
        redirect_valid = 1'b0;
        clear_q();
        for (int i = 0; i < 40 && pres_pc.size() < 1; i++) tick();
        checks += 2;
        if (acc_a.size() < 1 || acc_a[0] !== 32'h300) begin errors++; $display("FAIL rs_req got=%h exp=00000300", acc_a.size() ? acc_a[0] : 32'hx); end
        if (pres_pc.size() < 1 || pres_pc[0] !== 32'h300) begin errors++; $display("FAIL rs_pc got=%h exp=00000300", pres_pc.size() ? pres_pc[0] : 32'hx); end
    endtask
    task automatic test_hold_redirect();
        do_reset();
        for (int i = 0; i < 40 && !ivalid; i++) tick();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        clear_q();
        checks++;
        if (ivalid !== 1'b0) begin errors++; $display("FAIL hr_valid_drop got=%b exp=0", ivalid); end
        for (int i = 0; i < 40 && pres_pc.size() < 1; i++) tick();
        checks += 2;
        if (acc_a.size() < 1 || acc_a[0] !== 32'h200) begin errors++; $display("FAIL hr_req got=%h exp=00000200", acc_a.size() ? acc_a[0] : 32'hx); end
        if (pres_pc.size() < 1 || pres_pc[0] !== 32'h200) begin errors++; $display("FAIL hr_pc got=%h exp=00000200", pres_pc.size() ? pres_pc[0] : 32'hx); end
    endtask
    task automatic test_wrap();
        checks++;
        if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc got=%h exp=fffffffc", w_pc); end
        w_reset = 1'b0;
        for (int i = 0; i < 40 && (w_pres_pc.size() < 1 || w_acc.size() < 2); i++) tick();
        checks += 4;
        if (w_acc.size() < 2) begin
            errors++;
            $display("FAIL wrap_reqs got=%0d exp=2", w_acc.size());
        end else begin
            if (w_acc[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got=%h exp=fffffffc", w_acc[0]); end
            if (w_acc[1] !== 32'h0) begin errors++; $display("FAIL wrap_req1 got=%h exp=00000000", w_acc[1]); end
        end
        if (w_pres_pc.size() < 1 || w_pres_pc[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", w_pres_pc.size() ? w_pres_pc[0] : 32'hx); end
        if (w_pres_in.size() < 1 || w_pres_in[0] !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr got=%h exp=5a5afffc", w_pres_in.size() ? w_pres_in[0] : 32'hx); end
    endtask
    task automatic test_reset_in_wait();
        do_reset();
        instr_ready = 1'b1;
        mem_en = 1'b0;
        for (int i = 0; i < 40 && !req_valid; i++) tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_en = 1'b1;
        man_rsp = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        stray_ok = 1'b1;
        clear_q();
        tick();
        man_rsp = 1'b0;
        stray_ok = 1'b0;
        checks += 3;
        if (ivalid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid got=%b exp=0", ivalid); end
        if (req_valid !== 1'b1) begin errors++; $display("FAIL rst_wait_req got=%b exp=1", req_valid); end
        if (addr !== 32'h0) begin errors++; $display("FAIL rst_wait_addr got=%h exp=00000000", addr); end
        tick();
        checks++;
        if (ivalid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid2 got=%b exp=0", ivalid); end
        for (int i = 0; i < 40 && pres_pc.size() < 1; i++) tick();
        checks += 2;
        if (pres_pc.size() < 1 || pres_pc[0] !== 32'h0) begin errors++; $display("FAIL rst_wait_pc got=%h exp=00000000", pres_pc.size() ? pres_pc[0] : 32'hx); end
        if (pres_in.size() < 1 || pres_in[0] !== 32'hA5A5_0000) begin errors++; $display("FAIL rst_wait_instr got=%h exp=a5a50000", pres_in.size() ? pres_in[0] : 32'hx); end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_same();
        test_hold_redirect();
        test_wrap();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
